// File: rtl/memory_dp_rr_arbiter_pkg.sv
// mem_arb_pkg: shared types and helpers for memory_dp_rr_arbiter.
//
// Contents:
//   state_t      - arbiter state (INIT zero-fill, RUN normal arbitration)
//   MAX_NUM_REQ  - largest supported requester count
//   REQ_IDX_W    - width of a requester index able to address MAX_NUM_REQ
//   rr_next()    - round-robin winner search, returns a one-hot grant vector
package mem_arb_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_NUM_REQ = 16;
    localparam int REQ_IDX_W   = 4;

    // Search starts one past the last winner and wraps at num_req, so the
    // requester granted most recently always ends up with the lowest
    // priority. The sum last+k never exceeds 2*num_req-1, so a single
    // conditional subtract is enough to wrap it.
    function automatic logic [MAX_NUM_REQ-1:0] rr_next(
        input logic [REQ_IDX_W-1:0]   last,
        input logic [MAX_NUM_REQ-1:0] valid,
        input int                     num_req
    );
        logic [REQ_IDX_W:0] idx;
        logic               found;
        rr_next = '0;
        found   = 1'b0;
        for (int k = 1; k <= MAX_NUM_REQ; k++) begin
            idx = {1'b0, last} + (REQ_IDX_W+1)'(k);
            if (int'(idx) >= num_req) begin
                idx = idx - (REQ_IDX_W+1)'(num_req);
            end
            if ((k <= num_req) && !found && valid[idx[REQ_IDX_W-1:0]]) begin
                rr_next[idx[REQ_IDX_W-1:0]] = 1'b1;
                found                       = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/memory_if.sv
// memory_if: one port of a memory_dp instance.
//
// Signals:
//   enable      - access strobe for this cycle
//   wr_en       - 1 = write, 0 = read (meaningful only with enable)
//   addr        - word address
//   write_data  - write word
//   read_data   - read word, valid the cycle after a read access
// Modports:
//   src - the side issuing accesses (arbiter)
//   dst - the memory side
interface memory_if #(
    parameter int  ADDR_W = 1,
    parameter type data_t = logic [1:0]
);
    logic              enable;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    data_t             write_data;
    data_t             read_data;

    modport src (output enable, output wr_en, output addr, output write_data,
                 input read_data);
    modport dst (input enable, input wr_en, input addr, input write_data,
                 output read_data);
endinterface

// File: rtl/memory_dp_rr_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant generator with a registered last-grant pointer.
//
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset, points last_q at NUM_REQ-1
//   valid   - per-requester request valid
//   advance - high in cycles whose grant is actually taken; moves last_q
//   grant   - combinational one-hot winner (zero when nothing is valid)
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    logic [REQ_IDX_W-1:0]   last_q;
    logic [REQ_IDX_W-1:0]   win_idx;
    logic [MAX_NUM_REQ-1:0] grant_full;
    logic                   unused_grant_bits;

    // Requester slots above NUM_REQ are fed zero, so their grant bits stay 0.
    always_comb begin
        grant_full = rr_next(last_q, MAX_NUM_REQ'(valid), NUM_REQ);
    end

    assign grant             = grant_full[NUM_REQ-1:0];
    assign unused_grant_bits = ^grant_full;

    // Encode the one-hot winner back to an index for the pointer.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx = REQ_IDX_W'(i);
            end
        end
    end

    // Idle cycles keep the pointer, so priority does not drift while nobody asks.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_IDX_W'(NUM_REQ - 1);
        end else if (advance) begin
            last_q <= win_idx;
        end
    end

endmodule

// File: rtl/memory_dp_rr_arbiter.sv
// memory_dp_rr_arbiter: shares one memory_dp port among NUM_REQ requesters.
//
// Round-robin arbitration grants at most one request per cycle and drives
// the memory port from the winner. Read data (one-cycle latency) is routed
// back with a one-hot rsp_valid to the requester that issued the read.
//
// Optional feature macro: MEM_ARB_INIT_EN
//   When defined, an INIT sequencer zero-fills addresses 0..DEPTH-1 after
//   reset (one word per cycle) before any request is granted.
//
// Ports:
//   clk        - clock shared with memory_dp
//   rst        - synchronous active-high reset
//   mem_port   - memory_if.src port toward memory_dp
//   req_valid  - per-requester request valid
//   req_wr     - per-requester 1 = write, 0 = read
//   req_addr   - per-requester address
//   req_wdata  - per-requester write data
//   req_ready  - one-hot grant, same cycle as the accepted request
//   rsp_valid  - one-hot read response strobe
//   rsp_data   - read data broadcast to all requesters
//   init_done  - memory is available to requesters
module memory_dp_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DEPTH   = 2,
    parameter type data_t  = logic [1:0],
    parameter int  ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    memory_if.src              mem_port,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_wr,
    input  logic [ADDR_W-1:0]  req_addr  [NUM_REQ],
    input  data_t              req_wdata [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] rsp_valid,
    output data_t              rsp_data,
    output logic               init_done
);

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rd_pend_q;
    logic               run;
    logic               in_init;
    logic [ADDR_W-1:0]  init_addr;
    logic               mux_wr;
    logic [ADDR_W-1:0]  mux_addr;
    data_t              mux_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .valid   (req_valid),
        .advance (|req_ready),
        .grant   (grant)
    );

`ifdef MEM_ARB_INIT_EN
    state_t            state_q;
    logic [ADDR_W-1:0] init_cnt_q;

    // Zero-fill sequencer: one word per cycle, leaves INIT after DEPTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else if (state_q == INIT) begin
            if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_q <= RUN;
            end else begin
                init_cnt_q <= init_cnt_q + ADDR_W'(1);
            end
        end
    end

    assign run       = (state_q == RUN);
    assign in_init   = (state_q == INIT);
    assign init_addr = init_cnt_q;
`else
    assign run       = 1'b1;
    assign in_init   = 1'b0;
    assign init_addr = '0;
`endif

    // Outputs are gated by rst as well, so the reset cycle itself is quiet
    // and an in-flight response is dropped rather than delivered.
    assign req_ready = grant & {NUM_REQ{run && !rst}};
    assign init_done = run && !rst;
    assign rsp_valid = rst ? '0 : rd_pend_q;

    always_comb begin
        rsp_data = '0;
        if (!rst && (|rd_pend_q)) begin
            rsp_data = mem_port.read_data;
        end
    end

    // Winner mux; grant is one-hot so at most one iteration matches.
    always_comb begin
        mux_wr    = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mux_wr    = req_wr[i];
                mux_addr  = req_addr[i];
                mux_wdata = req_wdata[i];
            end
        end
    end

    // Memory port: INIT writes zeros, RUN forwards the accepted request,
    // idle cycles drive everything to zero.
    always_comb begin
        mem_port.enable     = 1'b0;
        mem_port.wr_en      = 1'b0;
        mem_port.addr       = '0;
        mem_port.write_data = '0;
        if (!rst) begin
            if (in_init) begin
                mem_port.enable = 1'b1;
                mem_port.wr_en  = 1'b1;
                mem_port.addr   = init_addr;
            end else if (|req_ready) begin
                mem_port.enable     = 1'b1;
                mem_port.wr_en      = mux_wr;
                mem_port.addr       = mux_addr;
                mem_port.write_data = mux_wdata;
            end
        end
    end

    // Remember who issued a read so the next cycle's data goes back to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= '0;
        end else begin
            rd_pend_q <= req_ready & {NUM_REQ{~mux_wr}};
        end
    end

endmodule

// File: doc/memory_dp_rr_arbiter.md
# memory_dp_rr_arbiter

Shares one port of a `memory_dp` instance between `NUM_REQ` requesters using round-robin arbitration. It grants at most one request per cycle and drives the `memory_if` port. It routes the one-cycle-latency read data back to the requester that issued the read. An optional clear sequencer zero-fills the memory after reset before any grant. The block sits directly in front of `mem_portA` or `mem_portB` of a `memory_dp`.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `DEPTH`, default 2: memory depth; must match the attached `memory_dp`.
- `data_t`, default `logic [1:0]`: memory word type.
- `ADDR_W`, default `$clog2(DEPTH)`, minimum 1: address width.

Ports (clock and reset first):
- `clk`, input, 1: single clock shared with `memory_dp`.
- `rst`, input, 1: reset; **synchronous, active-high**.
- `mem_port`, `memory_if.src`, interface: drives `enable`, `wr_en`, `addr`, `write_data`; samples `read_data`.
- `req_valid`, input, `NUM_REQ`: per-requester request valid.
- `req_wr`, input, `NUM_REQ`: 1 = write, 0 = read.
- `req_addr`, input, `NUM_REQ` x `ADDR_W`: request address.
- `req_wdata`, input, `NUM_REQ` x `data_t`: write data.
- `req_ready`, output, `NUM_REQ`: one-hot grant, asserted in the same cycle as the accepted request.
- `rsp_valid`, output, `NUM_REQ`: one-hot read-response strobe.
- `rsp_data`, output, `data_t`: read data, broadcast to all requesters; qualify with `rsp_valid`.
- `init_done`, output, 1: memory is available to requesters.

## Operation

Arbitration:
- Arbitration is combinational on `req_valid` and a registered last-grant pointer `last_q`.
- Search order is `last_q`+1, `last_q`+2, …, wrapping modulo `NUM_REQ`; the first valid requester wins.
- `req_ready[i]` = grant[i] AND the state is RUN.
- `last_q` updates to the winner only in cycles with a grant. Idle cycles leave it unchanged.
- Reset sets `last_q` = `NUM_REQ`-1, so requester 0 has the highest priority on the first grant.

Memory drive (RUN state):
- `enable` = OR of grants.
- `wr_en`, `addr`, `write_data` are muxed from the winner.
- `addr` and `write_data` are don't-care when `enable`=0; drive them as zero.

Read return:
- A granted read registers a one-hot `rd_pend_q` = grant.
- Next cycle: `rsp_valid` = `rd_pend_q` and `rsp_data` = `mem_port.read_data`.
- A granted write produces no response.

Request rules:
- A requester holds `req_valid` and its fields stable until `req_ready`. The arbiter does not check this.
- Full throughput: one grant every cycle. Back-to-back reads from different requesters return in grant order, one per cycle.

Address range: addresses ≥ `DEPTH` are not checked and pass through unchanged.

States:
- INIT: present only with `MEM_ARB_INIT_EN`.
- RUN: normal arbitration.

Reset (`rst`=1):
- Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `enable`=0, `init_done`=0.
- Internal state: `rd_pend_q`=0.
- Any in-flight read response is dropped.
- State goes to INIT if `MEM_ARB_INIT_EN` is defined, else RUN.

## Timing

- Request-to-grant: 0 cycles (combinational).
- Read latency: grant in cycle N gives `rsp_valid` in cycle N+1.
- Write: memory is updated at the clock edge ending the grant cycle.
- Read after write to the same address, granted in N+1: returns the new data in N+2.
- Without the macro, `init_done`=1 from the first cycle after `rst` deasserts.

## Configuration

Macro: `MEM_ARB_INIT_EN`.

Defined:
- After reset, the INIT state writes zero to addresses 0..`DEPTH`-1, one per cycle, using an `ADDR_W`-bit counter.
- During INIT: `enable`=1, `wr_en`=1, `write_data`=0, and all `req_ready`=0.
- After the write to `DEPTH`-1, the next cycle enters RUN and sets `init_done`=1.
- INIT takes exactly `DEPTH` cycles.
- Asserting `rst` mid-INIT restarts the sequence from address 0.

Not defined: there is no counter or INIT state, and `init_done` is constant 1 after reset.

## Structure

- Package `mem_arb_pkg`:
  - state enum {INIT, RUN};
  - `MAX_NUM_REQ` = 16;
  - function `rr_next(last, valid)` returning the one-hot winner.
- Sub-module `rr_arbiter`, parameter `NUM_REQ`: holds `last_q` and the grant logic, with inputs `valid` and `advance`.
- The top level holds the mux, `rd_pend_q`, and the INIT sequencer.

## Test plan

1. **Basic read.** `NUM_REQ`=4, `DEPTH`=8, with `MEM_ARB_INIT_EN` defined. Release reset, wait 8 cycles, then read address 5 from requester 2. Expect `rsp_valid`=4'b0100 one cycle after the grant, with `rsp_data`=0.
2. **Round robin.** All 4 requesters valid continuously from reset. Expect grant order 0,1,2,3,0,1,…, one grant per cycle, with no requester skipped.
3. **Write/read interleave.** Requester 1 writes 2'b11 to address 3 in cycle N; requester 3 reads address 3 in cycle N+1. Expect `rsp_valid`=4'b1000 and `rsp_data`=2'b11 in cycle N+2, and no response for the write.
4. **Pointer stability.** Grant requester 2, then idle 3 cycles, then assert requesters 0 and 3 together. Expect requester 3 granted first.
5. **Reset mid-INIT.** `DEPTH`=8; assert `rst` at INIT address 4. Expect the sequence to restart at 0, `init_done` to rise 8 cycles after release, and no `req_ready` before that.
6. **Reset drops a response.** Assert `rst` in the cycle after a read grant. Expect `rsp_valid`=0 in all following cycles.
